// File: rtl/msdap_pkg.sv
// Definitions shared by the MSDAP serial transmit and receive paths:
// the default word length and the transmit FSM state encoding.
package msdap_pkg;

  localparam int MSDAP_WIDTH = 40;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/piso_tx.sv
// Dual-channel (L/R) parallel-in serial-out transmitter with a one-word holding
// buffer; words go out MSB first, starting on the edge where Frame is sampled high.
module piso_tx
  import msdap_pkg::*;
#(
  parameter int WIDTH = MSDAP_WIDTH
) (
  input  logic             Dclk,
  input  logic             Reset_n,
  input  logic             Frame,
  input  logic [WIDTH-1:0] dataL,
  input  logic [WIDTH-1:0] dataR,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             OutputL,
  output logic             OutputR,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             underrun,
  output tx_state_t        dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  tx_state_t        state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] shl, shl_nxt, shr, shr_nxt;
  logic [WIDTH-1:0] holdl, holdl_nxt, holdr, holdr_nxt;
  logic             hold_full, hold_full_nxt;
  logic             outl_nxt, outr_nxt, busy_nxt, done_nxt, under_nxt;

  // Load handshake: a word is captured on any edge where load_valid and
  // load_ready are both 1; load_ready is the registered inverse of hold_full,
  // so a transfer edge (hold_full=1) can never coincide with a load.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    shl_nxt       = shl;
    shr_nxt       = shr;
    holdl_nxt     = holdl;
    holdr_nxt     = holdr;
    hold_full_nxt = hold_full;
    outl_nxt      = 1'b0;
    outr_nxt      = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    under_nxt     = 1'b0;

    if (load_valid && load_ready) begin
      hold_full_nxt = 1'b1;
      holdl_nxt     = dataL;
      holdr_nxt     = dataR;
    end

    // Frame restarts from any state: normal start, back-to-back or framing error.
    if (Frame) begin
      if (hold_full) begin
        state_nxt     = SHIFT;
        count_nxt     = LAST_CNT;
        outl_nxt      = holdl[WIDTH-1];
        outr_nxt      = holdr[WIDTH-1];
        shl_nxt       = {holdl[WIDTH-2:0], 1'b0};
        shr_nxt       = {holdr[WIDTH-2:0], 1'b0};
        busy_nxt      = 1'b1;
        hold_full_nxt = 1'b0;
      end else begin
        state_nxt = IDLE;
        under_nxt = 1'b1;
      end
    end else if (state == SHIFT && count != '0) begin
      count_nxt = count - CW'(1);
      outl_nxt  = shl[WIDTH-1];
      outr_nxt  = shr[WIDTH-1];
      shl_nxt   = {shl[WIDTH-2:0], 1'b0};
      shr_nxt   = {shr[WIDTH-2:0], 1'b0};
      busy_nxt  = 1'b1;
      done_nxt  = (count == CW'(1));
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge Dclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      count      <= '0;
      shl        <= '0;
      shr        <= '0;
      holdl      <= '0;
      holdr      <= '0;
      hold_full  <= 1'b0;
      load_ready <= 1'b1;
      OutputL    <= 1'b0;
      OutputR    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      shl        <= shl_nxt;
      shr        <= shr_nxt;
      holdl      <= holdl_nxt;
      holdr      <= holdr_nxt;
      hold_full  <= hold_full_nxt;
      load_ready <= ~hold_full_nxt;
      OutputL    <= outl_nxt;
      OutputR    <= outr_nxt;
      tx_busy    <= busy_nxt;
      tx_done    <= done_nxt;
      underrun   <= under_nxt;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: a vector table for underrun/backpressure plus
// hand-written sequences for single word, back-to-back, reset and framing error.
module tb_piso_tx;
  import msdap_pkg::*;

  localparam int W = 40;

  logic         dclk, reset_n, frame, load_valid;
  logic [W-1:0] data_l, data_r;
  logic         load_ready, out_l, out_r, tx_busy, tx_done, underrun;
  tx_state_t    dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int ecnt  = 0;

  logic [1:0] exp_q[$];

  typedef struct {
    logic         frame;
    logic         lv;
    logic [W-1:0] dl;
    logic [W-1:0] dr;
    logic         exp_ol;
    logic         exp_or;
    logic         exp_busy;
    logic         exp_done;
    logic         exp_und;
    logic         exp_rdy;
  } vec_t;

  vec_t tbl[6];

  piso_tx #(.WIDTH(W)) dut (
    .Dclk      (dclk),
    .Reset_n   (reset_n),
    .Frame     (frame),
    .dataL     (data_l),
    .dataR     (data_r),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .OutputL   (out_l),
    .OutputR   (out_r),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .underrun  (underrun),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (got running, expected finished)");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge dclk);
    #1;
    ecnt++;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", name, ecnt, got, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic ol, input logic orr,
                          input logic busy, input logic done, input logic und);
    chk({name, "_outl"}, 64'(out_l), 64'(ol));
    chk({name, "_outr"}, 64'(out_r), 64'(orr));
    chk({name, "_busy"}, 64'(tx_busy), 64'(busy));
    chk({name, "_done"}, 64'(tx_done), 64'(done));
    chk({name, "_under"}, 64'(underrun), 64'(und));
  endtask

  // Drives Frame on the first edge, then checks nbits serial bits of (l, r).
  // Optionally presents a new load (nl, nr) on iteration load_at.
  task automatic xmit(input logic [W-1:0] l, input logic [W-1:0] r,
                      input logic [W-1:0] nl, input logic [W-1:0] nr,
                      input int load_at, input int nbits);
    logic [1:0] e;
    int         i;
    for (int c = 0; c < nbits; c++) begin
      i = W - 1 - c;
      exp_q.push_back({l[i], r[i]});
      frame      = (c == 0);
      load_valid = (c == load_at);
      if (c == load_at) begin
        data_l = nl;
        data_r = nr;
      end
      tick();
      e = exp_q.pop_front();
      chk_outs("xmit", e[1], e[0], 1'b1, (i == 0), 1'b0);
    end
    frame      = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic load_word(input logic [W-1:0] l, input logic [W-1:0] r);
    load_valid = 1'b1;
    data_l     = l;
    data_r     = r;
    tick();
    load_valid = 1'b0;
    chk("load_ready_after_load", 64'(load_ready), 64'd0);
  endtask

  localparam logic [W-1:0] S_L  = 40'h80_0000_0001;
  localparam logic [W-1:0] S_R  = 40'h00_0000_0002;
  localparam logic [W-1:0] B_L  = 40'hC0_0000_00FF;
  localparam logic [W-1:0] B_R  = 40'h40_0000_0000;
  localparam logic [W-1:0] A_L  = 40'h96_1234_5678;
  localparam logic [W-1:0] A_R  = 40'h3C_0000_0001;
  localparam logic [W-1:0] C_L  = 40'h69_EDCB_A987;
  localparam logic [W-1:0] C_R  = 40'hC3_FFFF_FFFE;
  localparam logic [W-1:0] X_W  = 40'hFF_FFFF_FFFF;
  localparam logic [W-1:0] Y_W  = 40'hAA_AAAA_AAAA;
  localparam logic [W-1:0] F1_L = 40'h00_0000_0000;
  localparam logic [W-1:0] F1_R = 40'hFF_FFFF_FFFF;
  localparam logic [W-1:0] F2_L = 40'hF0_F0F0_F0F1;
  localparam logic [W-1:0] F2_R = 40'h0F_0F0F_0F0E;

  initial begin
    //            frame lv  dl   dr   ol   or   busy done und  rdy
    tbl[0] = '{1'b1, 1'b0, '0,  '0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 1'b0, '0,  '0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, A_L, A_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, C_L, C_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, '0,  '0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, C_L, C_R, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset_n    = 1'b0;
    frame      = 1'b0;
    load_valid = 1'b0;
    data_l     = '0;
    data_r     = '0;
    repeat (3) tick();
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_ready", 64'(load_ready), 64'd1);
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    reset_n = 1'b1;
    ecnt    = 0;

    // Single word with Frame at edge 10, then back-to-back word at edge 50.
    load_word(S_L, S_R);
    repeat (8) tick();
    chk_outs("pre_frame", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_frame_edge", 64'(ecnt), 64'd9);
    xmit(S_L, S_R, B_L, B_R, 5, W);
    chk("word1_end_edge", 64'(ecnt), 64'd49);
    xmit(B_L, B_R, '0, '0, -1, W);
    chk("word2_end_edge", 64'(ecnt), 64'd89);
    tick();
    chk_outs("after_b2b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_b2b_state", 64'(dbg_state), 64'(IDLE));

    // Underrun and backpressure vectors.
    for (int v = 0; v < 6; v++) begin
      frame      = tbl[v].frame;
      load_valid = tbl[v].lv;
      data_l     = tbl[v].dl;
      data_r     = tbl[v].dr;
      tick();
      chk_outs($sformatf("tbl%0d", v), tbl[v].exp_ol, tbl[v].exp_or,
               tbl[v].exp_busy, tbl[v].exp_done, tbl[v].exp_und);
      chk($sformatf("tbl%0d_ready", v), 64'(load_ready), 64'(tbl[v].exp_rdy));
    end
    frame      = 1'b0;
    load_valid = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      tick();
      chk_outs("bp_word", A_L[i], A_R[i], 1'b1, (i == 0), 1'b0);
    end
    tick();
    chk_outs("bp_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk_outs("bp_no_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word (after bits 39..20) with a second word held.
    load_word(X_W, X_W);
    xmit(X_W, X_W, Y_W, Y_W, 3, 20);
    chk("pre_reset_ready", 64'(load_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    chk_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_ready", 64'(load_ready), 64'd1);
    chk("mid_reset_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk_outs("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk_outs("post_reset_underrun", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_outs("underrun_pulse_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Framing error: Frame after 10 bits of F1 with F2 held.
    load_word(F1_L, F1_R);
    xmit(F1_L, F1_R, F2_L, F2_R, 2, 10);
    xmit(F2_L, F2_R, '0, '0, -1, W);
    tick();
    chk_outs("after_frame_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_frame_err_ready", 64'(load_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 40: serial word length in bits, range 2..64.
REQ-002 SHALL have port Dclk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Frame, input, 1 bit: frame sync; a 1 sampled on Dclk rising edge starts a word.
REQ-005 SHALL have port dataL, input, WIDTH bits: left-channel parallel word to send.
REQ-006 SHALL have port dataR, input, WIDTH bits: right-channel parallel word to send.
REQ-007 SHALL have port load_valid, input, 1 bit: dataL/dataR are valid for loading.
REQ-008 SHALL have port load_ready, output, 1 bit: holding buffer is empty and can accept a load.
REQ-009 SHALL have port OutputL, output, 1 bit: left serial data, MSB first.
REQ-010 SHALL have port OutputR, output, 1 bit: right serial data, MSB first.
REQ-011 SHALL have port tx_busy, output, 1 bit: a word is being shifted out.
REQ-012 SHALL have port tx_done, output, 1 bit: one-cycle pulse while the last bit (bit 0) is driven.
REQ-013 SHALL have port underrun, output, 1 bit: one-cycle pulse when Frame arrives with the holding buffer empty.

Function
REQ-014 SHALL store a word in the holding buffer (hold_full=1) on any edge where load_valid=1 and load_ready=1.
REQ-015 SHALL drive load_ready as a register equal to the inverse of hold_full.
REQ-016 SHALL ignore load_valid while load_ready=0, leaving held data unchanged.
REQ-017 SHALL use a two-state FSM, IDLE and SHIFT, plus a bit counter of width clog2(WIDTH).
REQ-018 SHALL, in IDLE with Frame=1 and hold_full=1 at edge k: move hold to the shift register, clear hold_full, drive bit WIDTH-1 from edge k, set count=WIDTH-1, and enter SHIFT.
REQ-019 SHALL, in IDLE with Frame=1 and hold_full=0: pulse underrun for one cycle, hold OutputL/OutputR at 0, and stay in IDLE.
REQ-020 SHALL, in SHIFT, decrement count each edge and drive bit count, so bits WIDTH-2..0 appear at edges k+1..k+WIDTH-1.
REQ-021 SHALL assert tx_busy from edge k through edge k+WIDTH-1, and assert tx_done only at edge k+WIDTH-1.
REQ-022 SHALL, at edge k+WIDTH, apply the IDLE rules of REQ-018/REQ-019, so back-to-back frames have no idle gap; otherwise outputs return to 0 and the FSM goes to IDLE.
REQ-023 SHALL treat Frame=1 in SHIFT with count≠0 as a framing error: abandon the current word and apply REQ-018/REQ-019 at that edge.
REQ-024 SHALL not accept a load at a transfer edge where hold_full was 1 (load_ready=0); load_ready rises the following cycle.
REQ-025 SHALL drive all outputs from registers, never combinationally from inputs.

Reset
REQ-026 SHALL, on Reset_n=0 at any time including mid-word, immediately enter IDLE and clear hold_full, count, and both buffers.
REQ-027 SHALL, during reset, hold OutputL, OutputR, tx_busy, tx_done and underrun at 0 and load_ready at 1.
REQ-028 SHALL, after Reset_n deasserts, start no transmission before a Frame=1 is sampled.

Structure
REQ-029 SHALL take the FSM state encoding (IDLE=0, SHIFT=1) and the default WIDTH from the shared msdap package, which also serves the receive side.
REQ-030 SHALL be a single module with no sub-modules; the L and R channels share one FSM and one counter.

Verification
REQ-031 SHALL test single word: WIDTH=40, load L=40'h80_0000_0001, R=40'h00_0000_0002, then Frame at edge 10 -> OutputL=1 at edge 10, 0 at edges 11..48, 1 at edge 49; OutputR=1 only at edge 48; tx_done=1 only at edge 49.
REQ-032 SHALL test back-to-back: second word loaded during SHIFT, Frame at edge 50 -> MSB at edge 50, tx_busy stays 1 continuously, no underrun.
REQ-033 SHALL test underrun: Frame with buffer empty -> underrun=1 for exactly one cycle, outputs stay 0, tx_busy=0.
REQ-034 SHALL test backpressure: two loads with no Frame -> first accepted, load_ready=0, second word discarded; the transmitted word equals the first.
REQ-035 SHALL test reset mid-word: Reset_n=0 at bit 20 -> outputs 0 in the same cycle, load_ready=1; after release, the next Frame with an empty buffer gives underrun.
REQ-036 SHALL test framing error: Frame at bit 10 of a word with the buffer full -> the new word's MSB is driven at that edge and the old word is abandoned.
